// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Per-key pushbutton conditioning: two-flop synchronizer,
//            polarity normalisation, counter-based debounce, one-cycle
//            press/release pulses and auto-repeat of press pulses while held.
// Ports    : CLOCK_50    - system clock, all state updates on rising edge
//            reset       - synchronous, active-high reset
//            key_raw     - asynchronous pushbutton pins (NUM_KEYS bits)
//            repeat_en   - global auto-repeat enable
//            key_level   - debounced key state, 1 = pressed
//            key_press   - one-cycle press and auto-repeat pulses
//            key_release - one-cycle release pulses
// Revision : 1.0 - initial release
// ============================================================================
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  // Raw pin value of a released key; also the synchronizer reset value.
  localparam logic             RELEASED    = (ACTIVE_LOW != 0);

  if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_params
    $error("key_conditioner: NUM_KEYS, DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    // 0: waiting for the first repeat (DELAY), 1: periodic repeats (PERIOD)
    logic             rpt_phase_q, rpt_phase_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    logic             sample;
    logic             deb_toggle;
    logic             rise, fall;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_fire;

    always_comb begin
      sample     = sync2_q ^ RELEASED;
      deb_toggle = (sample != level_q) && (deb_cnt_q == DEB_LAST);
      rise       = deb_toggle & ~level_q;
      fall       = deb_toggle & level_q;
      level_d    = level_q ^ deb_toggle;

      // Any cycle where the sample agrees with the level restarts the count,
      // so a glitch shorter than DEBOUNCE_CYCLES never reaches the toggle.
      if (sample == level_q || deb_toggle) begin
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end

      // A falling edge suppresses a coincident repeat so press and release
      // are never high together.
      rpt_target = rpt_phase_q ? PERIOD_LAST : DELAY_LAST;
      rpt_fire   = level_q & repeat_en & ~fall & (rpt_cnt_q == rpt_target);

      if (!level_q || !repeat_en || fall) begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
        rpt_phase_d = rpt_phase_q;
      end

      press_d   = rise | rpt_fire;
      release_d = fall;
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        sync1_q     <= RELEASED;
        sync2_q     <= RELEASED;
        deb_cnt_q   <= '0;
        level_q     <= 1'b0;
        rpt_cnt_q   <= '0;
        rpt_phase_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
      end else begin
        sync1_q     <= key_raw[i];
        sync2_q     <= sync1_q;
        deb_cnt_q   <= deb_cnt_d;
        level_q     <= level_d;
        rpt_cnt_q   <= rpt_cnt_d;
        rpt_phase_q <= rpt_phase_d;
        press_q     <= press_d;
        release_q   <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Purpose  : Directed self-checking bench for key_conditioner with
//            DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, active-low keys.
//            Inputs change 1 time unit after a rising edge and outputs are
//            checked at that same point, so "edge k" below means the k-th
//            rising edge after the input change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic          repeat_en;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .repeat_en  (repeat_en),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    key_raw   = 4'hF;
    repeat_en = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Reset dominates a pressed input and clears all outputs.
  task automatic test_reset();
    reset     = 1'b1;
    key_raw   = 4'h0;
    repeat_en = 1'b1;
    for (int k = 0; k < 8; k++) step();
    total_cnt++;
    if ({key_level, key_press, key_release} !== 12'h000)
      $display("FAIL reset_outputs: got %h required 000", {key_level, key_press, key_release});
    else pass_cnt++;
    key_raw = 4'hF;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) step();
    total_cnt++;
    if ({key_level, key_press, key_release} !== 12'h000)
      $display("FAIL idle_after_reset: got %h required 000", {key_level, key_press, key_release});
    else pass_cnt++;
  endtask

  // Key 0 pressed then released; level and pulses appear on edge 6.
  task automatic test_clean_press();
    logic [NK-1:0] exp_p, exp_l, exp_r;
    do_reset();
    key_raw = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_p = (k == 6) ? 4'b0001 : 4'b0000;
      exp_l = (k >= 6) ? 4'b0001 : 4'b0000;
      total_cnt++;
      if (key_press !== exp_p || key_level !== exp_l || key_release !== 4'b0000)
        $display("FAIL clean_press k=%0d: got p=%b l=%b r=%b required p=%b l=%b r=0000",
                 k, key_press, key_level, key_release, exp_p, exp_l);
      else pass_cnt++;
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_r = (k == 6) ? 4'b0001 : 4'b0000;
      exp_l = (k >= 6) ? 4'b0000 : 4'b0001;
      total_cnt++;
      if (key_release !== exp_r || key_level !== exp_l || key_press !== 4'b0000)
        $display("FAIL clean_release k=%0d: got p=%b l=%b r=%b required p=0000 l=%b r=%b",
                 k, key_press, key_level, key_release, exp_l, exp_r);
      else pass_cnt++;
    end
  endtask

  // Key 1 bounces low/high every 2 cycles; nothing passes until it settles.
  task automatic test_bounce();
    logic [NK-1:0] exp_p;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      key_raw = (((c / 2) % 2) == 0) ? 4'b1101 : 4'b1111;
      step();
      total_cnt++;
      if (key_press !== 4'b0000 || key_level !== 4'b0000)
        $display("FAIL bounce_quiet c=%0d: got p=%b l=%b required p=0000 l=0000",
                 c, key_press, key_level);
      else pass_cnt++;
    end
    key_raw = 4'b1101;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_p = (k == 6) ? 4'b0010 : 4'b0000;
      total_cnt++;
      if (key_press !== exp_p)
        $display("FAIL bounce_settle k=%0d: got %b required %b", k, key_press, exp_p);
      else pass_cnt++;
    end
  endtask

  // Key 2 held: press at P, repeats at P+10, P+13, P+16. Release driven after
  // P+13 falls on P+19, which is also when the next repeat was due.
  task automatic test_auto_repeat();
    logic exp_p, exp_r;
    do_reset();
    repeat_en = 1'b1;
    key_raw   = 4'b1011;
    for (int k = 0; k < 6; k++) step();
    total_cnt++;
    if (key_press !== 4'b0100)
      $display("FAIL repeat_initial: got %b required 0100", key_press);
    else pass_cnt++;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_p = (k == 10 || k == 13 || k == 16);
      exp_r = (k == 19);
      total_cnt++;
      if (key_press[2] !== exp_p || key_release[2] !== exp_r)
        $display("FAIL auto_repeat P+%0d: got p=%b r=%b required p=%b r=%b",
                 k, key_press[2], key_release[2], exp_p, exp_r);
      else pass_cnt++;
      if (k == 13) key_raw = 4'hF;
    end
  endtask

  // repeat_en low across P+6..P+8 restarts timing: next repeat at P+18.
  task automatic test_repeat_gating();
    logic exp_p;
    do_reset();
    repeat_en = 1'b1;
    key_raw   = 4'b1011;
    for (int k = 0; k < 6; k++) step();
    total_cnt++;
    if (key_press !== 4'b0100)
      $display("FAIL gating_initial: got %b required 0100", key_press);
    else pass_cnt++;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_p = (k == 18);
      total_cnt++;
      if (key_press[2] !== exp_p)
        $display("FAIL repeat_gating P+%0d: got %b required %b", k, key_press[2], exp_p);
      else pass_cnt++;
      if (k == 5) repeat_en = 1'b0;
      if (k == 8) repeat_en = 1'b1;
    end
  endtask

  // Keys 0 and 3 pressed and released together.
  task automatic test_simultaneous();
    logic [NK-1:0] exp_v;
    do_reset();
    key_raw = 4'b0110;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_v = (k == 6) ? 4'b1001 : 4'b0000;
      total_cnt++;
      if (key_press !== exp_v || key_release !== 4'b0000)
        $display("FAIL simul_press k=%0d: got p=%b r=%b required p=%b r=0000",
                 k, key_press, key_release, exp_v);
      else pass_cnt++;
    end
    key_raw = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_v = (k == 6) ? 4'b1001 : 4'b0000;
      total_cnt++;
      if (key_release !== exp_v || key_press !== 4'b0000)
        $display("FAIL simul_release k=%0d: got p=%b r=%b required p=0000 r=%b",
                 k, key_press, key_release, exp_v);
      else pass_cnt++;
    end
  endtask

  // Reset during debounce of a held key 0; press fires 6 edges after release
  // of reset, as a fresh press.
  task automatic test_reset_mid();
    logic [NK-1:0] exp_p;
    do_reset();
    key_raw = 4'b1110;
    for (int k = 0; k < 3; k++) step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total_cnt++;
      if (key_press !== 4'b0000 || key_level !== 4'b0000)
        $display("FAIL reset_mid_hold k=%0d: got p=%b l=%b required p=0000 l=0000",
                 k, key_press, key_level);
      else pass_cnt++;
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_p = (k == 6) ? 4'b0001 : 4'b0000;
      total_cnt++;
      if (key_press !== exp_p)
        $display("FAIL reset_mid_resume k=%0d: got %b required %b", k, key_press, exp_p);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_raw   = 4'hF;
    repeat_en = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_gating();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
